// File: rtl/cc_vecmux_scan.sv
// Multi-channel x/y/z sample multiplexer with manual channel select and timed scan.
// A strobe on the active channel is registered to the outputs one cycle later.
module cc_vecmux_scan #(
    parameter int unsigned N_WIDTH     = 17,
    parameter int unsigned N_CH        = 4,
    parameter int unsigned SEL_WIDTH   = 2,
    parameter int unsigned DWELL_WIDTH = 16
) (
    input  logic                      CC_VECMUX_SCAN_CLOCK_50,
    input  logic                      CC_VECMUX_SCAN_RESET_InLow,
    input  logic [N_CH*N_WIDTH-1:0]   CC_VECMUX_SCAN_x_InBus,
    input  logic [N_CH*N_WIDTH-1:0]   CC_VECMUX_SCAN_y_InBus,
    input  logic [N_CH*N_WIDTH-1:0]   CC_VECMUX_SCAN_z_InBus,
    input  logic [N_CH-1:0]           CC_VECMUX_SCAN_valid_InBus,
    input  logic                      CC_VECMUX_SCAN_mode_In,
    input  logic [SEL_WIDTH-1:0]      CC_VECMUX_SCAN_select_InBus,
    input  logic [DWELL_WIDTH-1:0]    CC_VECMUX_SCAN_dwell_InBus,
    output logic [N_WIDTH-1:0]        CC_VECMUX_SCAN_x_OutBus,
    output logic [N_WIDTH-1:0]        CC_VECMUX_SCAN_y_OutBus,
    output logic [N_WIDTH-1:0]        CC_VECMUX_SCAN_z_OutBus,
    output logic [SEL_WIDTH-1:0]      CC_VECMUX_SCAN_ch_OutBus,
    output logic                      CC_VECMUX_SCAN_valid_Out,
    output logic                      CC_VECMUX_SCAN_switch_Out
);

    typedef enum logic [0:0] {StManual, StScan} state_e;

    state_e                 state_q;
    logic [SEL_WIDTH-1:0]   ch_q, ch_d;
    logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
    logic [DWELL_WIDTH-1:0] dwell_eff;
    logic                   cap;
    logic [N_WIDTH-1:0]     x_sel, y_sel, z_sel;
    logic [N_WIDTH-1:0]     x_q, y_q, z_q;
    logic [SEL_WIDTH-1:0]   ch_out_q;
    logic                   valid_q, switch_q;

    // Channel picked by the pre-update ch so a switch-cycle sample comes from the old channel.
    always_comb begin
        cap   = 1'b0;
        x_sel = '0;
        y_sel = '0;
        z_sel = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (ch_q == SEL_WIDTH'(k)) begin
                cap   = CC_VECMUX_SCAN_valid_InBus[k];
                x_sel = CC_VECMUX_SCAN_x_InBus[k*N_WIDTH +: N_WIDTH];
                y_sel = CC_VECMUX_SCAN_y_InBus[k*N_WIDTH +: N_WIDTH];
                z_sel = CC_VECMUX_SCAN_z_InBus[k*N_WIDTH +: N_WIDTH];
            end
        end
    end

    assign dwell_eff = (CC_VECMUX_SCAN_dwell_InBus == '0) ? DWELL_WIDTH'(1)
                                                          : CC_VECMUX_SCAN_dwell_InBus;

    // Scan rules only while both the registered state and the mode input say scan;
    // leaving scan clears the counter and falls straight into manual selection.
    always_comb begin
        ch_d  = ch_q;
        cnt_d = '0;
        if (state_q == StScan && CC_VECMUX_SCAN_mode_In) begin
            if (cnt_q >= dwell_eff - DWELL_WIDTH'(1)) begin
                cnt_d = '0;
                ch_d  = (ch_q == SEL_WIDTH'(N_CH - 1)) ? '0 : ch_q + SEL_WIDTH'(1);
            end else begin
                cnt_d = cnt_q + DWELL_WIDTH'(1);
            end
        end else if ({1'b0, CC_VECMUX_SCAN_select_InBus} < (SEL_WIDTH + 1)'(N_CH)) begin
            ch_d = CC_VECMUX_SCAN_select_InBus;
        end
    end

    always_ff @(posedge CC_VECMUX_SCAN_CLOCK_50) begin
        if (!CC_VECMUX_SCAN_RESET_InLow) begin
            state_q  <= StManual;
            ch_q     <= '0;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            ch_out_q <= '0;
            valid_q  <= 1'b0;
            switch_q <= 1'b0;
        end else begin
            state_q  <= CC_VECMUX_SCAN_mode_In ? StScan : StManual;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            valid_q  <= cap;
            switch_q <= (ch_d != ch_q);
            if (cap) begin
                x_q      <= x_sel;
                y_q      <= y_sel;
                z_q      <= z_sel;
                ch_out_q <= ch_q;
            end
        end
    end

    assign CC_VECMUX_SCAN_x_OutBus   = x_q;
    assign CC_VECMUX_SCAN_y_OutBus   = y_q;
    assign CC_VECMUX_SCAN_z_OutBus   = z_q;
    assign CC_VECMUX_SCAN_ch_OutBus  = ch_out_q;
    assign CC_VECMUX_SCAN_valid_Out  = valid_q;
    assign CC_VECMUX_SCAN_switch_Out = switch_q;

endmodule

// File: tb/tb_cc_vecmux_scan.sv
// Scoreboard bench for cc_vecmux_scan: a cycle-level reference model predicts every
// output cycle, and an independent monitor compares on the falling edge.
module tb_cc_vecmux_scan;

    localparam int NW = 17;
    localparam int NC = 4;
    localparam int SW = 3;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NC*NW-1:0]  xb, yb, zb;
    logic [NC-1:0]     vb;
    logic              mode;
    logic [SW-1:0]     sel;
    logic [DW-1:0]     dwell;
    logic [NW-1:0]     xo, yo, zo;
    logic [SW-1:0]     cho;
    logic              vo, swo;

    cc_vecmux_scan #(
        .N_WIDTH    (NW),
        .N_CH       (NC),
        .SEL_WIDTH  (SW),
        .DWELL_WIDTH(DW)
    ) dut (
        .CC_VECMUX_SCAN_CLOCK_50    (clk),
        .CC_VECMUX_SCAN_RESET_InLow (rstn),
        .CC_VECMUX_SCAN_x_InBus     (xb),
        .CC_VECMUX_SCAN_y_InBus     (yb),
        .CC_VECMUX_SCAN_z_InBus     (zb),
        .CC_VECMUX_SCAN_valid_InBus (vb),
        .CC_VECMUX_SCAN_mode_In     (mode),
        .CC_VECMUX_SCAN_select_InBus(sel),
        .CC_VECMUX_SCAN_dwell_InBus (dwell),
        .CC_VECMUX_SCAN_x_OutBus    (xo),
        .CC_VECMUX_SCAN_y_OutBus    (yo),
        .CC_VECMUX_SCAN_z_OutBus    (zo),
        .CC_VECMUX_SCAN_ch_OutBus   (cho),
        .CC_VECMUX_SCAN_valid_Out   (vo),
        .CC_VECMUX_SCAN_switch_Out  (swo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic          vo;
        logic          sw;
        logic [SW-1:0] cho;
        logic [NW-1:0] x, y, z;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model state: active channel, cycles already spent on it, scan flag.
    int            m_ch = 0, m_spent = 0;
    bit            m_scan = 0;
    logic [NW-1:0] m_x = '0, m_y = '0, m_z = '0;
    logic [SW-1:0] m_cho = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            chk("valid_Out", 32'(vo), 32'(e.vo));
            chk("switch_Out", 32'(swo), 32'(e.sw));
            chk("ch_OutBus", 32'(cho), 32'(e.cho));
            chk("x_OutBus", 32'(xo), 32'(e.x));
            chk("y_OutBus", 32'(yo), 32'(e.y));
            chk("z_OutBus", 32'(zo), 32'(e.z));
        end
    end

    task automatic model_step();
        exp_t e;
        int   next_ch, eff;
        bit   cap;
        if (!rstn) begin
            m_ch = 0; m_spent = 0; m_scan = 0;
            m_x = '0; m_y = '0; m_z = '0; m_cho = '0;
            e.vo = 1'b0;
            e.sw = 1'b0;
        end else begin
            cap     = vb[m_ch];
            next_ch = m_ch;
            if (m_scan && mode) begin
                eff = (dwell == 0) ? 1 : int'(dwell);
                if (m_spent + 1 >= eff) begin
                    next_ch = (m_ch + 1) % NC;
                    m_spent = 0;
                end else begin
                    m_spent++;
                end
            end else begin
                m_spent = 0;
                if (int'(sel) < NC) next_ch = int'(sel);
            end
            if (cap) begin
                m_x   = xb[m_ch*NW +: NW];
                m_y   = yb[m_ch*NW +: NW];
                m_z   = zb[m_ch*NW +: NW];
                m_cho = SW'(m_ch);
            end
            e.vo   = cap;
            e.sw   = (next_ch != m_ch);
            m_ch   = next_ch;
            m_scan = mode;
        end
        e.cyc = cyc + 1;
        e.x   = m_x;
        e.y   = m_y;
        e.z   = m_z;
        e.cho = m_cho;
        q.push_back(e);
    endtask

    task automatic rnd_data();
        for (int k = 0; k < NC; k++) begin
            xb[k*NW +: NW] = NW'($urandom);
            yb[k*NW +: NW] = NW'($urandom);
            zb[k*NW +: NW] = NW'($urandom);
        end
    endtask

    task automatic cycle(input bit rnd);
        if (rnd) rnd_data();
        model_step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rstn = 1'b0; mode = 1'b0; sel = '0; dwell = '0; vb = '0;
        rnd_data();
        repeat (3) cycle(1);
        rstn = 1'b1;
        cycle(1);

        // Manual select of channel 2, then a sample on channel 2.
        sel = 3'd2;
        cycle(1);
        xb[2*NW +: NW] = 17'h00ABC;
        vb = 4'b0100;
        cycle(0);
        vb = '0;
        repeat (2) cycle(1);

        // Out-of-range selection holds the channel.
        sel = 3'd5;
        repeat (3) cycle(1);

        // Scan with dwell 3 from channel 0, every channel strobing.
        sel = 3'd0;
        cycle(1);
        vb = '1; dwell = 16'd3; mode = 1'b1;
        repeat (15) cycle(1);

        // Dwell 0 and dwell 1 both advance each cycle.
        dwell = 16'd0;
        repeat (8) cycle(1);
        dwell = 16'd1;
        repeat (8) cycle(1);

        // Dwell shrunk below the elapsed count forces an immediate advance.
        dwell = 16'd6;
        repeat (5) cycle(1);
        dwell = 16'd2;
        repeat (5) cycle(1);

        // Reset mid-dwell with a capture pending.
        dwell = 16'd5;
        repeat (2) cycle(1);
        rstn = 1'b0;
        cycle(1);
        rstn = 1'b1;
        repeat (4) cycle(1);

        // Scan back to manual.
        mode = 1'b0; sel = 3'd3;
        repeat (3) cycle(1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            if ($urandom_range(0, 14) == 0) dwell = DW'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) sel = SW'($urandom_range(0, 7));
            vb   = NC'($urandom);
            rstn = ($urandom_range(0, 199) != 0);
            cycle(1);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
